pulse_window_counter: RTL and testbench

PULSE_WINDOW_COUNTER -- requirements
Module: pulse_window_counter

---
 rtl/pulse_window_counter.sv | 137 +++++++++++++
 tb/tb_pulse_window_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_window_counter.sv
// rtl/pulse_window_counter.sv - counts pulses over fixed WIN_LEN-cycle windows, reports via valid/ready.
// Optional back-to-back pulse detection is enabled with `define PWC_GAP_CHECK_EN.
module pulse_window_counter #(
    parameter int CNT_W   = 8,
    parameter int WIN_LEN = 256
) (
    input  logic             clk_fast,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             en,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             sat,
    output logic             lost,
    output logic             gap_err
);

    localparam int               WIN_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HOLD
    } state_t;

    state_t           r_state;
    logic [WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_evt_cnt;
    logic             r_sat_int;
    logic [CNT_W-1:0] r_cnt_out;
    logic             r_cnt_valid;
    logic             r_sat;
    logic             r_lost;

    logic             w_at_max;
    logic             w_last;
    logic             w_handshake;
    logic [CNT_W-1:0] w_evt_next;
    logic             w_sat_next;

    assign w_at_max    = (r_evt_cnt == CNT_MAX);
    assign w_last      = (r_win_cnt == WIN_LAST);
    assign w_handshake = (r_state == ST_HOLD) && r_cnt_valid && cnt_ready;
    // Next count and saturation include this cycle's pulse so the last window cycle is reported.
    assign w_evt_next  = (pulse_in && !w_at_max) ? r_evt_cnt + CNT_W'(1) : r_evt_cnt;
    assign w_sat_next  = r_sat_int | (pulse_in & w_at_max);

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_win_cnt   <= '0;
            r_evt_cnt   <= '0;
            r_sat_int   <= 1'b0;
            r_cnt_out   <= '0;
            r_cnt_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_lost      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_state   <= ST_COUNT;
                        r_win_cnt <= '0;
                        r_evt_cnt <= '0;
                        r_sat_int <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (!en) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_win_cnt <= r_win_cnt + WIN_W'(1);
                        r_evt_cnt <= w_evt_next;
                        r_sat_int <= w_sat_next;
                        if (w_last) begin
                            r_state     <= ST_HOLD;
                            r_cnt_out   <= w_evt_next;
                            r_sat       <= w_sat_next;
                            r_cnt_valid <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_handshake) begin
                        r_cnt_valid <= 1'b0;
                        if (en) begin
                            r_state   <= ST_COUNT;
                            r_win_cnt <= '0;
                            r_evt_cnt <= '0;
                            r_sat_int <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // A pulse in the handshake cycle wins over the clear.
            if (pulse_in && (r_state != ST_COUNT)) begin
                r_lost <= 1'b1;
            end else if (w_handshake) begin
                r_lost <= 1'b0;
            end
        end
    end

    assign cnt_out   = r_cnt_out;
    assign cnt_valid = r_cnt_valid;
    assign sat       = r_sat;
    assign lost      = r_lost;

`ifdef PWC_GAP_CHECK_EN
    logic r_prev_pulse;
    logic r_gap_err;

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            r_prev_pulse <= 1'b0;
            r_gap_err    <= 1'b0;
        end else begin
            r_prev_pulse <= pulse_in;
            if (pulse_in && r_prev_pulse) begin
                r_gap_err <= 1'b1;
            end
        end
    end

    assign gap_err = r_gap_err;
`else
    assign gap_err = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_window_counter.sv
// tb/tb_pulse_window_counter.sv - directed self-checking bench for pulse_window_counter (CNT_W=4, WIN_LEN=16).
module tb_pulse_window_counter;

    logic       clk_fast = 1'b0;
    logic       rst;
    logic       pulse_in;
    logic       en;
    logic [3:0] cnt_out;
    logic       cnt_valid;
    logic       cnt_ready;
    logic       sat;
    logic       lost;
    logic       gap_err;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef PWC_GAP_CHECK_EN
    localparam logic EXP_GAP = 1'b1;
`else
    localparam logic EXP_GAP = 1'b0;
`endif

    pulse_window_counter #(.CNT_W(4), .WIN_LEN(16)) dut (
        .clk_fast  (clk_fast),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .en        (en),
        .cnt_out   (cnt_out),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .sat       (sat),
        .lost      (lost),
        .gap_err   (gap_err)
    );

    always #5 clk_fast = ~clk_fast;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_fast);
        #1;
    endtask

    // One full window: bit i of mask is the pulse on window cycle i.
    task automatic run_window(input logic [15:0] mask);
        for (int i = 0; i < 16; i++) begin
            pulse_in = mask[i];
            cyc();
            if (i == 14) check("no_early_valid", 32'(cnt_valid), 32'd0);
        end
        pulse_in = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        pulse_in  = 1'b0;
        cnt_ready = 1'b0;
        cyc();
        check("rst_valid", 32'(cnt_valid), 32'd0);
        check("rst_cnt",   32'(cnt_out),   32'd0);
        check("rst_sat",   32'(sat),       32'd0);
        check("rst_lost",  32'(lost),      32'd0);
        check("rst_gap",   32'(gap_err),   32'd0);
        rst = 1'b0;
    endtask

    initial begin
        // Five pulses 3 apart, last on window cycle 15; window restarts right after handshake.
        do_reset();
        en = 1'b1; cnt_ready = 1'b1;
        cyc();
        run_window(16'b1001_0010_0100_1000);
        check("a_valid", 32'(cnt_valid), 32'd1);
        check("a_cnt",   32'(cnt_out),   32'd5);
        check("a_sat",   32'(sat),       32'd0);
        cyc();
        check("a_valid_drop", 32'(cnt_valid), 32'd0);
        run_window(16'b0000_0001_0000_0001);
        check("a2_valid", 32'(cnt_valid), 32'd1);
        check("a2_cnt",   32'(cnt_out),   32'd2);
        check("a2_lost",  32'(lost),      32'd0);

        // Saturation: 16 pulses saturate, 15 pulses reach max without sat.
        do_reset();
        en = 1'b1; cnt_ready = 1'b0;
        cyc();
        run_window(16'hFFFF);
        check("b_valid", 32'(cnt_valid), 32'd1);
        check("b_cnt",   32'(cnt_out),   32'd15);
        check("b_sat",   32'(sat),       32'd1);
        check("b_gap",   32'(gap_err),   32'(EXP_GAP));
        check("b_lost",  32'(lost),      32'd0);
        cnt_ready = 1'b1;
        cyc();
        cnt_ready = 1'b0;
        run_window(16'hFFFE);
        check("b2_cnt", 32'(cnt_out), 32'd15);
        check("b2_sat", 32'(sat),     32'd0);

        // Report held 10 cycles while pulses arrive and en toggles.
        do_reset();
        en = 1'b1;
        cyc();
        run_window(16'b0000_0000_1010_0100);
        check("c_cnt", 32'(cnt_out), 32'd3);
        for (int i = 0; i < 10; i++) begin
            en       = (i % 2) == 1;
            pulse_in = (i == 2) || (i == 6);
            cyc();
            check("c_hold_valid", 32'(cnt_valid), 32'd1);
            check("c_hold_cnt",   32'(cnt_out),   32'd3);
            check("c_hold_sat",   32'(sat),       32'd0);
        end
        pulse_in = 1'b0;
        check("c_lost_set", 32'(lost), 32'd1);
        en = 1'b1; cnt_ready = 1'b1;
        cyc();
        check("c_valid_drop", 32'(cnt_valid), 32'd0);
        check("c_lost_clr",   32'(lost),      32'd0);
        cnt_ready = 1'b0;
        run_window(16'b0000_0000_0001_0000);
        check("c2_valid", 32'(cnt_valid), 32'd1);
        check("c2_cnt",   32'(cnt_out),   32'd1);

        // Abort at window cycle 7; pulse in abort cycle is discarded.
        do_reset();
        en = 1'b1;
        cyc();
        for (int i = 0; i < 7; i++) begin
            pulse_in = (i == 1) || (i == 4);
            cyc();
        end
        en = 1'b0; pulse_in = 1'b1;
        cyc();
        pulse_in = 1'b0;
        check("d_valid", 32'(cnt_valid), 32'd0);
        check("d_lost_abort", 32'(lost), 32'd0);
        pulse_in = 1'b1;
        cyc();
        pulse_in = 1'b0;
        check("d_idle_lost", 32'(lost), 32'd1);
        en = 1'b1;
        cyc();
        run_window(16'b0000_0100_0000_0000);
        check("d2_valid", 32'(cnt_valid), 32'd1);
        check("d2_cnt",   32'(cnt_out),   32'd1);

        // Reset at window cycle 10 after 3 pulses, then reset mid-HOLD.
        do_reset();
        en = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) begin
            pulse_in = (i == 2) || (i == 5) || (i == 8);
            cyc();
        end
        pulse_in = 1'b0;
        rst = 1'b1;
        cyc();
        check("e_valid", 32'(cnt_valid), 32'd0);
        check("e_cnt",   32'(cnt_out),   32'd0);
        check("e_sat",   32'(sat),       32'd0);
        check("e_lost",  32'(lost),      32'd0);
        rst = 1'b0;
        cyc();
        run_window(16'b0000_0000_0000_1010);
        check("e2_valid", 32'(cnt_valid), 32'd1);
        check("e2_cnt",   32'(cnt_out),   32'd2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("e3_valid", 32'(cnt_valid), 32'd0);
        check("e3_cnt",   32'(cnt_out),   32'd0);

        // Single pulse in IDLE with en low.
        do_reset();
        pulse_in = 1'b1;
        cyc();
        pulse_in = 1'b0;
        check("f_lost",  32'(lost),      32'd1);
        check("f_valid", 32'(cnt_valid), 32'd0);
        cyc();
        check("f_lost_sticky", 32'(lost),      32'd1);
        check("f_valid2",      32'(cnt_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
